seq_divider: RTL

- Sequential restoring divider; the inverse of the team's 4x4 array multiplier.
- Takes a 2W-bit dividend (multiplier product width) and a W-bit divisor.
- Returns a 2W-bit quotient and a W-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic test harness, so a product can be divided back by either factor.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 135 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_W_DEFAULT = 4;
    localparam int unsigned CNT_W = $clog2(2 * DIV_W_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step-counter width for a given operand width (counts 2W-1 down to 0).
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W_DEFAULT
) (
    input  logic [W-1:0] p,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] p_next_c,
    output logic         q_bit_c
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // The partial remainder stays below the divisor, so the shifted value is
    // under twice the divisor and the top bit of the trial is a true sign.
    always_comb begin
        shifted  = {p, bit_in};
        trial    = shifted - {1'b0, divisor};
        q_bit_c  = ~trial[W];
        p_next_c = q_bit_c ? trial[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, 2W/W -> 2W quotient and W remainder, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero
);

    localparam int unsigned DW = 2 * W;
    localparam int unsigned CW = cnt_width(W);

    state_t          state;
    logic [W-1:0]    prem;
    logic [DW-1:0]   dreg;
    logic [W-1:0]    dvsr;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    prem_nxt;
    logic            q_bit;
    logic [DW-1:0]   dreg_nxt;
    logic [DW-1:0]   dvd_mag;
    logic [W-1:0]    dvs_mag;
    logic [DW-1:0]   q_fin;
    logic [W-1:0]    r_fin;

    div_step #(.W(W)) u_step (
        .p        (prem),
        .bit_in   (dreg[DW-1]),
        .divisor  (dvsr),
        .p_next_c (prem_nxt),
        .q_bit_c  (q_bit)
    );

    assign dreg_nxt = {dreg[DW-2:0], q_bit};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Divide magnitudes, then restore signs on the final step.
    always_comb begin
        dvd_mag = dividend[DW-1] ? (DW'(0) - dividend) : dividend;
        dvs_mag = divisor[W-1]   ? (W'(0) - divisor)   : divisor;
        q_fin   = neg_q ? (DW'(0) - dreg_nxt) : dreg_nxt;
        r_fin   = neg_r ? (W'(0) - prem_nxt)  : prem_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= dividend[DW-1] ^ divisor[W-1];
            neg_r <= dividend[DW-1];
        end
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        q_fin   = dreg_nxt;
        r_fin   = prem_nxt;
    end
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prem      <= '0;
            dreg      <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[W-1:0];
                            div_zero  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            prem     <= '0;
                            dreg     <= dvd_mag;
                            dvsr     <= dvs_mag;
                            cnt      <= CW'(DW - 1);
                            div_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    prem <= prem_nxt;
                    dreg <= dreg_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= q_fin;
                        remainder <= r_fin;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
